// File: rtl/mat_mem_master.sv
// mat_mem_master: command-driven master for an M x N row-major matrix memory.
// Define MAT_MEM_MASTER_BURST_EN to add whole-row burst reads (cmd_burst/rsp_last).
module mat_mem_master #(
  parameter int DW = 8,
  parameter int M = 8,
  parameter int N = 8,
  localparam int AW = M + N + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [7:0]    cmd_row,
  input  logic [7:0]    cmd_col,
  input  logic [DW-1:0] cmd_wdata,
`ifdef MAT_MEM_MASTER_BURST_EN
  input  logic          cmd_burst,
  output logic          rsp_last,
`endif
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [2:0] {IDLE, WR, RD, CAP, RSP} state_t;
  state_t state;
  logic in_range;
  logic [AW-1:0] addr_n;
`ifdef MAT_MEM_MASTER_BURST_EN
  logic burst, burst_rd;
  logic [7:0] col;
  // a burst read ignores cmd_col and starts at column 0
  assign burst_rd = cmd_burst && !cmd_we;
  assign in_range = 32'(cmd_row) < M && (burst_rd || 32'(cmd_col) < N);
  assign addr_n = AW'(cmd_row) * AW'(N) + (burst_rd ? '0 : AW'(cmd_col));
`else
  assign in_range = 32'(cmd_row) < M && 32'(cmd_col) < N;
  assign addr_n = AW'(cmd_row) * AW'(N) + AW'(cmd_col);
`endif
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == RSP;
  assign mem_we = state == WR;
  assign mem_re = state == RD;
  assign mem_en = mem_we | mem_re;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mem_addr <= '0;
      mem_wdata <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
`ifdef MAT_MEM_MASTER_BURST_EN
      burst <= 1'b0;
      col <= '0;
      rsp_last <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          mem_addr <= addr_n;
          mem_wdata <= AW'(cmd_wdata);
          rsp_data <= '0;
          rsp_err <= !in_range;
          state <= !in_range ? RSP : cmd_we ? WR : RD;
`ifdef MAT_MEM_MASTER_BURST_EN
          burst <= burst_rd && in_range;
          col <= '0;
          rsp_last <= 1'b1;
`endif
        end
        WR: state <= IDLE;
        RD: state <= CAP;
        CAP: begin
          rsp_data <= mem_rdata;
          rsp_err <= 1'b0;
`ifdef MAT_MEM_MASTER_BURST_EN
          rsp_last <= !burst || col == 8'(N - 1);
`endif
          state <= RSP;
        end
        RSP: if (rsp_ready) begin
`ifdef MAT_MEM_MASTER_BURST_EN
          if (burst && !rsp_last) begin
            col <= col + 8'd1;
            mem_addr <= mem_addr + AW'(1);
            state <= RD;
          end else state <= IDLE;
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_mem_master.sv
// tb_mat_mem_master: table-driven, hand-sequenced and randomized checks against a matrix model.
module tb_mat_mem_master;
  localparam int AW = 17;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_we = 0, rsp_ready = 1;
  logic [7:0] cmd_row = 0, cmd_col = 0, cmd_wdata = 0;
  logic cmd_ready, rsp_valid, rsp_err, mem_en, mem_we, mem_re, busy;
  logic [7:0] rsp_data, mem_rdata = 0;
  logic [AW-1:0] mem_addr, mem_wdata;
`ifdef MAT_MEM_MASTER_BURST_EN
  logic cmd_burst = 0, rsp_last;
`endif
  int tests = 0, fails = 0;
  logic [7:0] mem [int];
  logic [7:0] ref_mem [8][8];

  mat_mem_master dut (.clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_wdata(cmd_wdata),
`ifdef MAT_MEM_MASTER_BURST_EN
    .cmd_burst(cmd_burst), .rsp_last(rsp_last),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[int'(mem_addr)] = mem_wdata[7:0];
    if (mem_en && mem_re) mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one command from IDLE; expectations come from the caller
  task automatic run_cmd(input bit we, input logic [7:0] row, col, wd, input bit exp_err, input logic [7:0] exp_data);
    logic [31:0] a;
    a = 32'(row) * 8 + 32'(col);
    @(negedge clk);
    cmd_valid = 1; cmd_we = we; cmd_row = row; cmd_col = col; cmd_wdata = wd;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0; cmd_we = ~we; cmd_row = 8'($urandom); cmd_col = 8'($urandom); cmd_wdata = 8'($urandom);
    if (exp_err) begin
      chk("err_mem_en", mem_en, 0);
      chk("err_rsp_valid", rsp_valid, 1);
      chk("err_rsp_err", rsp_err, 1);
      chk("err_rsp_data", rsp_data, 0);
    end else if (we) begin
      chk("wr_strobes", {mem_en, mem_we, mem_re}, 3'b110);
      chk("wr_addr", mem_addr, a);
      chk("wr_wdata", mem_wdata, 32'(wd));
      chk("wr_no_rsp", rsp_valid, 0);
      ref_mem[row][col] = wd;
    end else begin
      chk("rd_strobes", {mem_en, mem_we, mem_re}, 3'b101);
      chk("rd_addr", mem_addr, a);
      @(negedge clk);
      chk("cap_quiet", {rsp_valid, mem_en}, 2'b00);
      @(negedge clk);
      chk("rd_rsp_valid_t3", rsp_valid, 1);
      chk("rd_rsp_err", rsp_err, 0);
      chk("rd_rsp_data", rsp_data, exp_data);
    end
    @(negedge clk);
    chk("back_idle", {cmd_ready, busy, rsp_valid, mem_en}, 4'b1000);
  endtask

  typedef struct {bit we; logic [7:0] row, col, wd; bit err; logic [7:0] data;} vec_t;
  vec_t tbl[10];

  initial begin
    int n;
    bit w, ok;
    logic [7:0] r, c, d;
    foreach (ref_mem[i, j]) ref_mem[i][j] = 0;
    tbl[0] = '{1, 2, 3, 8'hA5, 0, 0};
    tbl[1] = '{0, 2, 3, 0, 0, 8'hA5};
    tbl[2] = '{0, 8, 0, 0, 1, 0};
    tbl[3] = '{1, 0, 0, 8'h5A, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 8'h5A};
    tbl[5] = '{1, 3, 8, 8'h11, 1, 0};
    tbl[6] = '{0, 255, 255, 0, 1, 0};
    tbl[7] = '{1, 7, 7, 8'hFF, 0, 0};
    tbl[8] = '{0, 7, 7, 0, 0, 8'hFF};
    tbl[9] = '{0, 2, 3, 0, 0, 8'hA5};
    #12;
    chk("reset_outs", {rsp_valid, rsp_err, mem_en, mem_we, mem_re, busy, cmd_ready}, 7'b0000001);
    chk("reset_data", {rsp_data, 15'(mem_addr), 15'(mem_wdata)}, 0);
    @(negedge clk); rst_n = 1;
    foreach (tbl[i]) run_cmd(tbl[i].we, tbl[i].row, tbl[i].col, tbl[i].wd, tbl[i].err, tbl[i].data);
    // stall with rsp_ready low for 10 cycles
    rsp_ready = 0;
    @(negedge clk); cmd_valid = 1; cmd_we = 0; cmd_row = 2; cmd_col = 3;
    @(negedge clk); cmd_valid = 0;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold", {rsp_valid, rsp_err, rsp_data, mem_en, cmd_ready}, {2'b10, 8'hA5, 2'b00});
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("stall_release", {cmd_ready, rsp_valid}, 2'b10);
    // reset during RD aborts without a response
    @(negedge clk); cmd_valid = 1; cmd_we = 0; cmd_row = 7; cmd_col = 7;
    @(negedge clk); cmd_valid = 0;
    chk("abort_in_rd", mem_re, 1);
    rst_n = 0; #1;
    chk("abort_async", {busy, mem_en, cmd_ready}, 3'b001);
    #2 rst_n = 1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n += int'(rsp_valid) + int'(busy);
    end
    chk("abort_no_rsp", n, 0);
    // back-to-back writes: one acceptance per 2 cycles
    n = 0;
    cmd_valid = 1; cmd_we = 1; cmd_row = 4; cmd_col = 4; cmd_wdata = 8'h33;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n += int'(mem_we);
    end
    cmd_valid = 0;
    chk("b2b_writes", n, 5);
    ref_mem[4][4] = 8'h33;
    @(negedge clk);
    // randomized commands against the matrix model
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      r = 8'($urandom_range(0, 9));
      c = 8'($urandom_range(0, 9));
      d = 8'($urandom);
      ok = r < 8 && c < 8;
      run_cmd(w, r, c, d, !ok, ok ? ref_mem[r[2:0]][c[2:0]] : 8'h00);
    end
`ifdef MAT_MEM_MASTER_BURST_EN
    for (int k = 0; k < 8; k++) run_cmd(1, 1, 8'(k), 8'(8'h40 + k), 0, 0);
    @(negedge clk); cmd_valid = 1; cmd_we = 0; cmd_burst = 1; cmd_row = 1; cmd_col = 5;
    @(negedge clk); cmd_valid = 0; cmd_burst = 0;
    for (int k = 0; k < 8; k++) begin
      chk("burst_rd_addr", {mem_re, 15'(mem_addr)}, {1'b1, 15'(8 + k)});
      @(negedge clk); @(negedge clk);
      chk("burst_rsp", {rsp_valid, rsp_err, rsp_last, rsp_data}, {2'b10, k == 7, ref_mem[1][k]});
      @(negedge clk);
    end
    chk("burst_done", cmd_ready, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mat_mem_master.md
MAT_MEM_MASTER -- requirements
Module: mat_mem_master

Interface
REQ-001 Parameter DW, default 8: element data width, equal to the matrix memory word width.
REQ-002 Parameter M, default 8: matrix rows; M SHALL be in the range 1..256.
REQ-003 Parameter N, default 8: matrix columns; N SHALL be in the range 1..256; AW = M+N+1.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-008 cmd_we  in  1  1 = write, 0 = read.
REQ-009 cmd_row  in  8  row index.
REQ-010 cmd_col  in  8  column index.
REQ-011 cmd_wdata  in  DW  write element.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high at a rising edge.
REQ-014 rsp_data  out  DW  read element; 0 on error.
REQ-015 rsp_err  out  1  out-of-range command.
REQ-016 mem_en, mem_we, mem_re  out  1 each  memory enable, write strobe and read strobe.
REQ-017 mem_addr  out  AW  element address.
REQ-018 mem_wdata  out  AW  write data, cmd_wdata zero-extended.
REQ-019 mem_rdata  in  DW  memory read data, valid in the cycle after a read strobe.
REQ-020 busy  out  1  high whenever the state is not IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, WR, RD, CAP and RSP; cmd_ready SHALL be high only in IDLE.
REQ-022 A command SHALL be in range iff cmd_row < M and cmd_col < N; address = cmd_row*N + cmd_col, computed at full AW width with no truncation.
REQ-023 The command fields SHALL be registered at acceptance; later input changes SHALL have no effect.
REQ-024 IDLE -> WR on an accepted in-range write; -> RD on an accepted in-range read; -> RSP with rsp_err=1 and rsp_data=0 on any accepted out-of-range command, with no memory access.
REQ-025 In WR: mem_en=1, mem_we=1, mem_re=0 for exactly one cycle, then -> IDLE; an in-range write SHALL produce no response.
REQ-026 In RD: mem_en=1, mem_re=1, mem_we=0 for exactly one cycle, then -> CAP.
REQ-027 In CAP: mem_rdata SHALL be registered into rsp_data with rsp_err=0, then -> RSP.
REQ-028 rsp_valid SHALL be high only in RSP, and rsp_data/rsp_err SHALL be held stable until the handshake completes; on completion -> IDLE.
REQ-029 mem_en, mem_we, mem_re and mem_addr SHALL be decoded from registered state only; mem_we and mem_re SHALL never be high together; mem_en SHALL be 0 outside WR and RD.
REQ-030 Read latency SHALL be fixed: acceptance edge at cycle T, then RD in T+1, CAP in T+2, rsp_valid high in T+3.
REQ-031 Back-to-back writes SHALL sustain one accepted command every 2 cycles.
REQ-032 Holding rsp_ready low SHALL stall indefinitely with no additional memory access.

Reset
REQ-033 While rst_n=0: state=IDLE; cmd_ready=1 (once released); rsp_valid, rsp_err, rsp_data, mem_en, mem_we, mem_re, mem_addr, mem_wdata and busy SHALL all be 0.
REQ-034 A reset asserted mid-operation SHALL abort the operation with no response; a write already strobed is not undone.

Configuration
REQ-035 With MAT_MEM_MASTER_BURST_EN defined, an input cmd_burst (1 bit) and an output rsp_last (1 bit) SHALL exist.
REQ-036 With the macro defined, an accepted read with cmd_burst=1 and cmd_row<M (cmd_col ignored) SHALL read columns 0..N-1 of that row in order, each column traversing RD->CAP->RSP.
REQ-037 In a burst, rsp_last SHALL be high only with the column N-1 response; rsp_last SHALL also be high on every single read and every error response.
REQ-038 A burst write SHALL be treated as a normal single write.
REQ-039 Without the macro, cmd_burst and rsp_last SHALL be absent and all commands SHALL be single-element.

Verification
REQ-040 Reset, then write (row 2, col 3, 0xA5) -> mem_addr=19, mem_we=1 for one cycle, mem_wdata=0x00A5, no response.
REQ-041 Read (2,3) with the memory model returning 0xA5 -> rsp_valid at T+3, rsp_data=0xA5, rsp_err=0.
REQ-042 Read (8,0) with M=8 -> no mem_en, rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-043 rsp_ready held low for 10 cycles -> rsp_data stable, mem_en=0 throughout, cmd_ready=0.
REQ-044 rst_n pulsed low in the cycle RD is active -> next cycle IDLE, rsp_valid never asserted.
REQ-045 With MAT_MEM_MASTER_BURST_EN, burst read row 1 -> 8 responses from addresses 8..15 in order, rsp_last high only on the 8th.
